// File: rtl/ex_muldiv_if.sv
// Request/response bundle between the ID/EX stage and the EX-stage multiply/divide unit.
// Latency: none, wires only.
// Backpressure: start/O_ready on the request side, O_out_valid/I_out_ready on the result side.
// Signals: I_start, O_ready, I_op, I_word, I_src1, I_src2, I_flush, O_busy, O_out_valid, I_out_ready, O_result.
interface ex_muldiv_if #(
    parameter int XLEN = 64
);
    logic            I_start;
    logic            O_ready;
    logic [2:0]      I_op;
    logic            I_word;
    logic [XLEN-1:0] I_src1;
    logic [XLEN-1:0] I_src2;
    logic            I_flush;
    logic            O_busy;
    logic            O_out_valid;
    logic            I_out_ready;
    logic [XLEN-1:0] O_result;

    modport master (
        output I_start, I_op, I_word, I_src1, I_src2, I_flush, I_out_ready,
        input  O_ready, O_busy, O_out_valid, O_result
    );

    modport slave (
        input  I_start, I_op, I_word, I_src1, I_src2, I_flush, I_out_ready,
        output O_ready, O_busy, O_out_valid, O_result
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative RV64M multiply/divide unit (shift-add multiply, restoring divide), one bit per cycle.
// Latency: start accepted in cycle c -> O_out_valid in c+N+1 (N=32 word ops, 64 otherwise); c+1 for divide special cases.
// Backpressure: result held under O_out_valid until I_out_ready; a new start is taken only when IDLE or in the transfer cycle.
// Ports: I_sys_clk, I_rst (synchronous, active-high), bus (slave modport of ex_muldiv_if).
module ex_muldiv_unit #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 7
) (
    input  logic       I_sys_clk,
    input  logic       I_rst,
    ex_muldiv_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [2*XLEN-1:0]   acc;      // product for mul, remainder in [XLEN-1:0] for div
    logic [2*XLEN-1:0]   mcand;    // shifted multiplicand for mul, divisor in [XLEN-1:0] for div
    logic [XLEN-1:0]     q;        // multiplier (shifts right) or dividend/quotient (shifts left)
    logic [2:0]          op_r;
    logic                word_r;
    logic                neg_q;    // sign of product / quotient
    logic                neg_r;    // sign of remainder (follows dividend)
    logic                out_valid;
    logic [XLEN-1:0]     result;

    // ---------------- operand preparation ----------------
    logic            ready, accept, w_in, s1_sgn, s2_sgn;
    logic            a_neg, b_neg, div_zero, div_ovf;
    logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, special_raw, special_res;

    always_comb begin
        ready  = (state == IDLE) || (state == DONE && bus.I_out_ready);
        accept = bus.I_start && ready && !bus.I_flush;
        // W variants exist only for mul and the divide group
        w_in   = bus.I_word && (bus.I_op == 3'd0 || bus.I_op[2]);
        // mul/mulh/mulhsu/div/rem treat rs1 as signed; rs2 signed for mul/mulh/div/rem
        s1_sgn = bus.I_op[2] ? !bus.I_op[0] : (bus.I_op != 3'd3);
        s2_sgn = bus.I_op[2] ? !bus.I_op[0] : !bus.I_op[1];
        if (w_in) begin
            a_ext = {{(XLEN-32){s1_sgn & bus.I_src1[31]}}, bus.I_src1[31:0]};
            b_ext = {{(XLEN-32){s2_sgn & bus.I_src2[31]}}, bus.I_src2[31:0]};
        end else begin
            a_ext = bus.I_src1;
            b_ext = bus.I_src2;
        end
        a_neg = s1_sgn && a_ext[XLEN-1];
        b_neg = s2_sgn && b_ext[XLEN-1];
        a_mag = a_neg ? -a_ext : a_ext;
        b_mag = b_neg ? -b_ext : b_ext;

        // The word form of the most-negative value is already sign-extended in a_ext
        div_zero = bus.I_op[2] && (b_ext == '0);
        div_ovf  = bus.I_op[2] && !bus.I_op[0] && (b_ext == '1) &&
                   (a_ext == (w_in ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}}));
        if (div_zero)
            special_raw = bus.I_op[1] ? a_ext : '1;
        else
            special_raw = bus.I_op[1] ? '0 : a_ext;
        special_res = w_in ? {{(XLEN-32){special_raw[31]}}, special_raw[31:0]} : special_raw;
    end

    // ---------------- one iteration + final result ----------------
    logic [2*XLEN-1:0] acc_n, prod;
    logic [XLEN:0]     r_sh, r_dif;
    logic              ge;
    logic [XLEN-1:0]   rem_n, q_div_n, q_mul_n, q_fix, r_fix, sel, fin;

    always_comb begin
        acc_n   = q[0] ? acc + mcand : acc;
        q_mul_n = q >> 1;
        r_sh    = {acc[XLEN-1:0], q[XLEN-1]};
        // r_sh < 2*divisor, so the 65-bit difference's top bit is a clean borrow
        r_dif   = r_sh - {1'b0, mcand[XLEN-1:0]};
        ge      = !r_dif[XLEN];
        rem_n   = ge ? r_dif[XLEN-1:0] : r_sh[XLEN-1:0];
        q_div_n = {q[XLEN-2:0], ge};

        prod  = neg_q ? -acc_n : acc_n;
        q_fix = neg_q ? -q_div_n : q_div_n;
        r_fix = neg_r ? -rem_n : rem_n;
        case (op_r)
            3'd0:       sel = prod[XLEN-1:0];
            3'd1, 3'd2,
            3'd3:       sel = prod[2*XLEN-1:XLEN];
            3'd4, 3'd5: sel = q_fix;
            default:    sel = r_fix;
        endcase
        fin = word_r ? {{(XLEN-32){sel[31]}}, sel[31:0]} : sel;
    end

    // ---------------- control and datapath registers ----------------
    always_ff @(posedge I_sys_clk) begin
        if (I_rst) begin
            state     <= IDLE;
            cnt       <= '0;
            acc       <= '0;
            mcand     <= '0;
            q         <= '0;
            op_r      <= '0;
            word_r    <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
        end else if (bus.I_flush) begin
            state     <= IDLE;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        op_r   <= bus.I_op;
                        word_r <= w_in;
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                        cnt    <= w_in ? CNT_W'(32) : CNT_W'(XLEN);
                        acc    <= '0;
                        if (bus.I_op[2]) begin
                            mcand <= {{XLEN{1'b0}}, b_mag};
                            // word dividend pre-shifted so its MSB enters first
                            q     <= w_in ? {a_mag[31:0], 32'b0} : a_mag;
                        end else begin
                            mcand <= {{XLEN{1'b0}}, a_mag};
                            q     <= b_mag;
                        end
                        if (div_zero || div_ovf) begin
                            result    <= special_res;
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end else begin
                            state     <= CALC;
                            out_valid <= 1'b0;
                        end
                    end else if (state == DONE && bus.I_out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                CALC: begin
                    if (op_r[2]) begin
                        acc <= {{XLEN{1'b0}}, rem_n};
                        q   <= q_div_n;
                    end else begin
                        acc   <= acc_n;
                        mcand <= mcand << 1;
                        q     <= q_mul_n;
                    end
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        result    <= fin;
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.O_ready     = ready;
    assign bus.O_busy      = (state != IDLE);
    assign bus.O_out_valid = out_valid;
    assign bus.O_result    = result;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed vectors, random ops against an arithmetic model,
// backpressure, back-to-back, flush and mid-operation reset.
// Inputs driven at the falling edge, outputs sampled at the falling edge.
module tb_ex_muldiv_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ex_muldiv_if #(.XLEN(64)) bus ();

    ex_muldiv_unit #(.XLEN(64), .CNT_W(7)) dut (
        .I_sys_clk (clk),
        .I_rst     (rst),
        .bus       (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [2:0]  op;
        logic        w;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    // ---------------- reference model ----------------
    function automatic logic is_word(input logic [2:0] op, input logic word);
        return word && (op == 3'd0 || op >= 3'd4);
    endfunction

    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic word,
                                               input logic [63:0] a, input logic [63:0] b);
        logic [127:0] p;
        logic [63:0]  r;
        logic [31:0]  s32;
        longint sa, sb, sq, sr;
        longint unsigned ua, ub, uq, ur;
        int a32, b32, q32, r32;
        int unsigned ua32, ub32, uq32, ur32;
        logic w;
        w = is_word(op, word);
        r = '0;
        case (op)
            3'd0: begin
                p = {64'b0, a} * {64'b0, b};
                r = w ? {{32{p[31]}}, p[31:0]} : p[63:0];
            end
            3'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; r = p[127:64]; end
            3'd2: begin p = {{64{a[63]}}, a} * {64'b0, b};       r = p[127:64]; end
            3'd3: begin p = {64'b0, a} * {64'b0, b};             r = p[127:64]; end
            3'd4, 3'd6: begin
                if (w) begin
                    a32 = a[31:0];
                    b32 = b[31:0];
                    if (b32 == 0) begin q32 = -1; r32 = a32; end
                    else if (a32 == 32'sh8000_0000 && b32 == -1) begin q32 = a32; r32 = 0; end
                    else begin q32 = a32 / b32; r32 = a32 % b32; end
                    r = (op == 3'd4) ? longint'(q32) : longint'(r32);
                end else begin
                    sa = a;
                    sb = b;
                    if (sb == 0) begin sq = -1; sr = sa; end
                    else if (sa == 64'sh8000_0000_0000_0000 && sb == -1) begin sq = sa; sr = 0; end
                    else begin sq = sa / sb; sr = sa % sb; end
                    r = (op == 3'd4) ? sq : sr;
                end
            end
            default: begin
                if (w) begin
                    ua32 = a[31:0];
                    ub32 = b[31:0];
                    if (ub32 == 0) begin uq32 = 32'hFFFF_FFFF; ur32 = ua32; end
                    else begin uq32 = ua32 / ub32; ur32 = ua32 % ub32; end
                    s32 = (op == 3'd5) ? uq32 : ur32;
                    r = {{32{s32[31]}}, s32};
                end else begin
                    ua = a;
                    ub = b;
                    if (ub == 0) begin uq = '1; ur = ua; end
                    else begin uq = ua / ub; ur = ua % ub; end
                    r = (op == 3'd5) ? uq : ur;
                end
            end
        endcase
        return r;
    endfunction

    // cycles from the accepting edge until O_out_valid is first seen
    function automatic int ref_latency(input logic [2:0] op, input logic word,
                                       input logic [63:0] a, input logic [63:0] b);
        logic w;
        logic signed_op;
        w = is_word(op, word);
        signed_op = (op == 3'd4 || op == 3'd6);
        if (op >= 3'd4) begin
            if (w ? (b[31:0] == 32'd0) : (b == 64'd0)) return 1;
            if (signed_op && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                                : (a == 64'h8000_0000_0000_0000 && b == '1))) return 1;
        end
        return w ? 33 : 65;
    endfunction

    function automatic logic [63:0] pick_operand();
        logic [63:0] v;
        case ($urandom_range(0, 7))
            0:       v = 64'h8000_0000_0000_0000;
            1:       v = '1;
            2:       v = 64'(32'h8000_0000);
            3:       v = 64'd0;
            4:       v = 64'($urandom_range(0, 40));
            default: v = {$urandom(), $urandom()};
        endcase
        return v;
    endfunction

    // ---------------- stimulus helpers (caller sits at a falling edge) ----------------
    task automatic issue(input logic [2:0] op, input logic word, input logic [63:0] a, input logic [63:0] b);
        bus.I_op    = op;
        bus.I_word  = word;
        bus.I_src1  = a;
        bus.I_src2  = b;
        bus.I_start = 1'b1;
        @(posedge clk);
        #1 bus.I_start = 1'b0;
    endtask

    task automatic wait_valid(output logic [63:0] res, output int lat);
        lat = 1;
        @(negedge clk);
        while (!bus.O_out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        res = bus.O_result;
    endtask

    task automatic run_op(input logic [2:0] op, input logic word, input logic [63:0] a,
                          input logic [63:0] b, output logic [63:0] res, output int lat);
        issue(op, word, a, b);
        wait_valid(res, lat);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (bus.O_out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus.O_out_valid); end
        total++; if (bus.O_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.O_busy); end
        total++; if (bus.O_result !== 64'd0) begin bad++; $display("FAIL reset_result: got %h want 0", bus.O_result); end
        total++; if (bus.O_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", bus.O_ready); end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        vec_t dv[14];
        logic [63:0] res;
        int lat;
        dv[0]  = '{3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65};
        dv[1]  = '{3'd1, 1'b0, 64'h8000_0000_0000_0000, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65};
        dv[2]  = '{3'd3, 1'b0, 64'h8000_0000_0000_0000, 64'd2, 64'h0000_0000_0000_0001, 65};
        dv[3]  = '{3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 65};
        dv[4]  = '{3'd4, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1};
        dv[5]  = '{3'd6, 1'b0, 64'd5, 64'd0, 64'd5, 1};
        dv[6]  = '{3'd4, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1};
        dv[7]  = '{3'd6, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1};
        dv[8]  = '{3'd4, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1};
        dv[9]  = '{3'd4, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33};
        dv[10] = '{3'd6, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33};
        dv[11] = '{3'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd2, 64'h0000_0000_7FFF_FFFF, 33};
        dv[12] = '{3'd0, 1'b1, 64'h1_0000, 64'h1_0000, 64'd0, 33};
        // W bit must be ignored for mulh
        dv[13] = '{3'd1, 1'b1, 64'h8000_0000_0000_0000, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65};
        bus.I_out_ready = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 14; i++) begin
            run_op(dv[i].op, dv[i].w, dv[i].a, dv[i].b, res, lat);
            total++;
            if (res !== dv[i].exp) begin
                bad++; $display("FAIL dir_result[%0d] op=%0d: got %h want %h", i, dv[i].op, res, dv[i].exp);
            end
            total++;
            if (lat !== dv[i].lat) begin
                bad++; $display("FAIL dir_latency[%0d] op=%0d: got %0d want %0d", i, dv[i].op, lat, dv[i].lat);
            end
        end
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic        w;
        logic [63:0] a, b, res;
        int lat;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            w  = 1'($urandom_range(0, 1));
            a  = pick_operand();
            b  = pick_operand();
            run_op(op, w, a, b, res, lat);
            total++;
            if (res !== ref_result(op, w, a, b)) begin
                bad++; $display("FAIL rand_result[%0d] op=%0d w=%0d a=%h b=%h: got %h want %h",
                                i, op, w, a, b, res, ref_result(op, w, a, b));
            end
            total++;
            if (lat !== ref_latency(op, w, a, b)) begin
                bad++; $display("FAIL rand_latency[%0d] op=%0d w=%0d: got %0d want %0d",
                                i, op, w, lat, ref_latency(op, w, a, b));
            end
        end
    endtask

    task automatic test_backpressure_b2b();
        logic [63:0] a, b, res, held;
        int lat;
        @(negedge clk);                       // let the previous result transfer
        bus.I_out_ready = 1'b0;
        a = {$urandom(), $urandom()};
        b = {$urandom(), $urandom()};
        run_op(3'd3, 1'b0, a, b, held, lat);
        total++;
        if (held !== ref_result(3'd3, 1'b0, a, b)) begin
            bad++; $display("FAIL bp_result: got %h want %h", held, ref_result(3'd3, 1'b0, a, b));
        end
        for (int i = 0; i < 5; i++) begin
            bus.I_op = 3'd0; bus.I_word = 1'b0; bus.I_src1 = 64'd1; bus.I_src2 = 64'd1;
            bus.I_start = 1'b1;
            @(negedge clk);
            total++; if (bus.O_out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d]: got %b want 1", i, bus.O_out_valid); end
            total++; if (bus.O_result !== held) begin bad++; $display("FAIL bp_stable[%0d]: got %h want %h", i, bus.O_result, held); end
            total++; if (bus.O_ready !== 1'b0) begin bad++; $display("FAIL bp_ready[%0d]: got %b want 0", i, bus.O_ready); end
        end
        // ready rises together with a new start
        bus.I_out_ready = 1'b1;
        a = {$urandom(), $urandom()};
        b = 64'($urandom()) | 64'd1;
        run_op(3'd5, 1'b0, a, b, res, lat);
        total++;
        if (res !== ref_result(3'd5, 1'b0, a, b)) begin
            bad++; $display("FAIL b2b_result: got %h want %h", res, ref_result(3'd5, 1'b0, a, b));
        end
        total++;
        if (lat !== 65) begin bad++; $display("FAIL b2b_latency: got %0d want 65", lat); end
    endtask

    task automatic test_flush();
        logic [63:0] res;
        int lat;
        int seen;
        @(negedge clk);
        issue(3'd0, 1'b0, {$urandom(), $urandom()}, {$urandom(), $urandom()});
        repeat (9) @(posedge clk);            // now in cycle c+10
        #1 bus.I_flush = 1'b1;
        @(negedge clk);
        total++; if (bus.O_busy !== 1'b1) begin bad++; $display("FAIL flush_busy_before: got %b want 1", bus.O_busy); end
        @(posedge clk);
        #1 bus.I_flush = 1'b0;
        @(negedge clk);
        total++; if (bus.O_busy !== 1'b0) begin bad++; $display("FAIL flush_busy_after: got %b want 0", bus.O_busy); end
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            if (bus.O_out_valid) seen++;
            @(negedge clk);
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL flush_no_valid: got %0d valid cycles want 0", seen); end

        // flush beats a simultaneous start
        bus.I_op = 3'd0; bus.I_word = 1'b0; bus.I_src1 = 64'd3; bus.I_src2 = 64'd3;
        bus.I_start = 1'b1; bus.I_flush = 1'b1;
        @(posedge clk);
        #1 bus.I_start = 1'b0; bus.I_flush = 1'b0;
        @(negedge clk);
        total++; if (bus.O_busy !== 1'b0) begin bad++; $display("FAIL flush_vs_start: busy got %b want 0", bus.O_busy); end

        // flush beats a pending handshake
        bus.I_out_ready = 1'b0;
        run_op(3'd6, 1'b0, 64'd100, 64'd7, res, lat);
        bus.I_flush = 1'b1;
        @(posedge clk);
        #1 bus.I_flush = 1'b0;
        @(negedge clk);
        total++; if (bus.O_out_valid !== 1'b0) begin bad++; $display("FAIL flush_done_valid: got %b want 0", bus.O_out_valid); end
        bus.I_out_ready = 1'b1;

        run_op(3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, res, lat);
        total++;
        if (res !== 64'hFFFF_FFFF_FFFF_FFF2) begin bad++; $display("FAIL flush_fresh: got %h want fffffffffffffff2", res); end
        total++;
        if (lat !== 65) begin bad++; $display("FAIL flush_fresh_latency: got %0d want 65", lat); end
    endtask

    task automatic test_rst_mid();
        logic [63:0] res;
        int lat;
        run_op(3'd0, 1'b0, 64'd3, 64'd5, res, lat);
        total++; if (res !== 64'd15) begin bad++; $display("FAIL rst_pre: got %h want f", res); end
        issue(3'd1, 1'b0, {$urandom(), $urandom()}, {$urandom(), $urandom()});
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++; if (bus.O_out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid: got %b want 0", bus.O_out_valid); end
        total++; if (bus.O_busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy: got %b want 0", bus.O_busy); end
        total++; if (bus.O_result !== 64'd0) begin bad++; $display("FAIL rst_mid_result: got %h want 0", bus.O_result); end
        rst = 1'b0;
        run_op(3'd7, 1'b1, 64'd1000, 64'd7, res, lat);
        total++; if (res !== 64'd6) begin bad++; $display("FAIL rst_fresh: got %h want 6", res); end
        total++; if (lat !== 33) begin bad++; $display("FAIL rst_fresh_latency: got %0d want 33", lat); end
    endtask

    initial begin
        rst             = 1'b1;
        bus.I_start     = 1'b0;
        bus.I_op        = 3'd0;
        bus.I_word      = 1'b0;
        bus.I_src1      = 64'd0;
        bus.I_src2      = 64'd0;
        bus.I_flush     = 1'b0;
        bus.I_out_ready = 1'b1;
        test_reset();
        test_directed();
        test_random();
        test_backpressure_b2b();
        test_flush();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Iterative RV64M multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.
- Accepts one multicycle ALU operation per start pulse (ID/EX multicycle flag) and iterates one bit per cycle.
- Returns the result with a valid/ready handshake; its valid feeds the ID/EX alu-output-valid input, which gates ID/EX allowin.

Parameters:
- XLEN, 64, operand/result width; only 64 is supported.
- CNT_W, 7, iteration counter width; must hold XLEN.

Ports:
- I_sys_clk  in  1  clock
- I_rst  in  1  reset, synchronous, active-high
- I_start  in  1  start request; operands sampled when accepted
- O_ready  out  1  start acceptance: high when IDLE, or when DONE and I_out_ready is high
- I_op  in  3  0 mul, 1 mulh, 2 mulhsu, 3 mulhu, 4 div, 5 divu, 6 rem, 7 remu
- I_word  in  1  W variant; honoured for ops 0 and 4-7, ignored for ops 1-3
- I_src1  in  64  rs1 operand
- I_src2  in  64  rs2 operand
- I_flush  in  1  abort current operation
- O_busy  out  1  state != IDLE
- O_out_valid  out  1  result valid
- I_out_ready  in  1  downstream accepts result
- O_result  out  64  result, held while O_out_valid is high

Behaviour:
- Reset: state IDLE; O_out_valid, O_busy and O_result are 0; counter and internal registers are 0. Reset mid-operation aborts with no output.
- States:
  - IDLE -> CALC on accepted start.
  - IDLE -> DONE on accepted start when the operation is a special case.
  - CALC -> DONE when the counter reaches 0.
  - DONE -> IDLE on I_out_ready when no new start is accepted.
  - DONE -> CALC or DONE on a back-to-back start.
- Accept rule: start is accepted when I_start && O_ready && !I_flush. Start is ignored otherwise and is not queued.
- Operand prep at acceptance:
  - Word ops: operands are src[31:0], sign-extended for signed ops and zero-extended for unsigned ops.
  - Signed operands are converted to magnitudes; the result sign is recorded.
  - Counter is loaded with N = 32 for word ops, 64 otherwise.
- CALC: one iteration per edge.
  - Multiply: shift-add on a 128-bit accumulator.
  - Divide: restoring shift-subtract with 64-bit remainder and quotient.
  - Counter decrements on each iteration.
  - On the last iteration edge, O_result is computed with sign fix-up applied and state enters DONE.
- Latency:
  - Start accepted in cycle c: O_out_valid is first high in cycle c+N+1.
  - Special cases: O_out_valid is first high in cycle c+1.
- Result selection:
  - mul: product[63:0].
  - mulh/mulhsu/mulhu: product[127:64] (signed×signed, signed×unsigned, unsigned×unsigned).
  - div/divu: quotient. rem/remu: remainder.
  - Remainder sign follows the dividend.
  - Word ops: the 32-bit result is sign-extended to 64, including divuw/remuw.
- Special cases (no iteration):
  - Divide by zero: quotient is all ones; remainder is the dividend.
  - Signed overflow (most-negative / -1): quotient is the dividend; remainder is 0.
  - Word variants of both cases use the 32-bit values, then sign-extend.
- Handshake:
  - O_out_valid stays high and O_result stays stable until I_out_ready.
  - The transfer occurs in the cycle where O_out_valid && I_out_ready.
  - O_result keeps its last value after transfer.
- Flush:
  - I_flush in any state sends state to IDLE at the next edge and clears O_out_valid.
  - Flush has priority over start and over handshake.
  - A flushed result is never delivered.

Test Plan:
- mul with src1=7, src2=0xFFFFFFFFFFFFFFFD, start in cycle c -> O_result=0xFFFFFFFFFFFFFFEB, O_out_valid first high in cycle c+65.
- mulh with 0x8000000000000000 × 2 -> 0xFFFFFFFFFFFFFFFF. mulhu with the same operands -> 0x0000000000000001. mulhsu with 0xFFFFFFFFFFFFFFFF × 0xFFFFFFFFFFFFFFFF -> 0xFFFFFFFFFFFFFFFF.
- Special cases, each with valid in cycle c+1:
  - div 5/0 -> 0xFFFFFFFFFFFFFFFF; rem 5/0 -> 5.
  - div 0x8000000000000000 / -1 -> 0x8000000000000000; rem -> 0.
  - divw 0x80000000 / 0xFFFFFFFF -> 0xFFFFFFFF80000000.
- Word ops:
  - divw -7/2 -> 0xFFFFFFFFFFFFFFFD with valid at c+33; remw -7/2 -> 0xFFFFFFFFFFFFFFFF.
  - divuw with src1=0xFFFFFFFF_FFFFFFFE, src2=2 -> 0x000000007FFFFFFF.
  - mulw 0x10000 × 0x10000 -> 0.
- Backpressure and back-to-back:
  - Hold I_out_ready=0 for 5 cycles in DONE -> O_result stable; I_start pulses ignored.
  - Raise I_out_ready together with a new start -> the new operation's result is valid N+1 cycles later.
- Flush and reset:
  - I_flush at cycle c+10 of a 64-cycle op -> O_busy=0 at c+11; no O_out_valid.
  - I_rst mid-CALC -> all outputs 0 next cycle.
  - A fresh start after either -> correct result.
